// File: rtl/es_pkg.sv
// rtl/es_pkg.sv - shared types and helpers for the es multiplier job path
package es_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LAUNCH  = 2'd1,
    RUN     = 2'd2,
    RESULT  = 2'd3
  } es_job_state_t;

  localparam int ES_DEFAULT_TIMEOUT = 4096;

  function automatic int es_res_width(input int dw, input int ni);
    return dw * ni;
  endfunction

endpackage

// File: rtl/es_operand_collector.sv
// rtl/es_operand_collector.sv - gathers serial operand words into the multiplier operand array
module es_operand_collector
  import es_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             accept,
  input  logic [DATA_WIDTH-1:0]            word,
  output logic [DATA_WIDTH*NUM_INPUTS-1:0] mul_data,
  output logic                             last_word
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_INPUTS - 1);

  logic [IDX_W-1:0] idx;

  assign last_word = (idx == IDX_LAST);

  // Slot idx is written only on an accepted word, so mul_data stays frozen while a job runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      mul_data <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (idx == IDX_W'(i)) begin
          mul_data[i*DATA_WIDTH +: DATA_WIDTH] <= word;
        end
      end
      idx <= last_word ? '0 : IDX_W'(idx + 1'b1);
    end
  end

endmodule

// File: rtl/es_mul_job_ctrl.sv
// rtl/es_mul_job_ctrl.sv - job sequencer around es_naive_mul: operand collect, launch, run, result
module es_mul_job_ctrl
  import es_pkg::*;
#(
  parameter int DATA_WIDTH     = 5,
  parameter int NUM_INPUTS     = 2,
  parameter int RES_WIDTH      = es_res_width(DATA_WIDTH, NUM_INPUTS),
  parameter int TIMEOUT_CYCLES = ES_DEFAULT_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             op_valid,
  output logic                             op_ready,
  input  logic [DATA_WIDTH-1:0]            op_data,
  output logic                             mul_clr,
  output logic                             mul_en,
  output logic [DATA_WIDTH*NUM_INPUTS-1:0] mul_data,
  input  logic [RES_WIDTH-1:0]             mul_result,
  input  logic                             mul_done,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [RES_WIDTH-1:0]             res_data,
  output logic                             res_err,
  output logic                             busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  es_job_state_t    state;
  logic [CNT_W-1:0] run_cnt;
  logic             accept;
  logic             last_word;
  logic             timeout_hit;

  assign accept = op_valid && op_ready && (state == COLLECT);

  // run_cnt holds the number of RUN cycles already completed, so the match marks the final allowed cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (run_cnt == TO_LAST);

  es_operand_collector #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_INPUTS(NUM_INPUTS)
  ) u_collector (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .word     (op_data),
    .mul_data (mul_data),
    .last_word(last_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= COLLECT;
      op_ready  <= 1'b0;
      mul_clr   <= 1'b0;
      mul_en    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
      run_cnt   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          op_ready <= 1'b1;
          if (accept && last_word) begin
            state    <= LAUNCH;
            op_ready <= 1'b0;
            mul_clr  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LAUNCH: begin
          state   <= RUN;
          mul_clr <= 1'b0;
          mul_en  <= 1'b1;
          run_cnt <= '0;
        end
        RUN: begin
          run_cnt <= (run_cnt == CNT_MAX) ? run_cnt : run_cnt + 1'b1;
          // A done arriving on the timeout cycle still delivers the real product.
          if (mul_done) begin
            state     <= RESULT;
            mul_en    <= 1'b0;
            res_valid <= 1'b1;
            res_data  <= mul_result;
            res_err   <= 1'b0;
          end else if (timeout_hit) begin
            state     <= RESULT;
            mul_en    <= 1'b0;
            res_valid <= 1'b1;
            res_data  <= '0;
            res_err   <= 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            state     <= COLLECT;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            op_ready  <= 1'b1;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_es_mul_job_ctrl.sv
// tb/tb_es_mul_job_ctrl.sv - randomized job-level bench for es_mul_job_ctrl
module tb_es_mul_job_ctrl;

  localparam int DW = 5;
  localparam int NI = 2;
  localparam int RW = 10;
  localparam int TO = 48;
  localparam int P_COL = 0, P_LAU = 1, P_RUN = 2, P_RES = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            op_valid, op_ready;
  logic [DW-1:0]   op_data;
  logic            mul_clr, mul_en;
  logic [DW*NI-1:0] mul_data;
  logic [RW-1:0]   mul_result;
  logic            mul_done;
  logic            res_valid, res_ready;
  logic [RW-1:0]   res_data;
  logic            res_err, busy;

  always #5 clk = ~clk;

  es_mul_job_ctrl #(
    .DATA_WIDTH(DW), .NUM_INPUTS(NI), .RES_WIDTH(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .mul_clr(mul_clr), .mul_en(mul_en), .mul_data(mul_data),
    .mul_result(mul_result), .mul_done(mul_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .busy(busy)
  );

  typedef struct { int lat; int res; } job_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: job phase, operands, timing bookkeeping
  int            ph;
  int            idx;
  logic [DW-1:0] ops [NI];
  bit            m_rdy;
  logic [RW-1:0] m_res;
  bit            m_err;
  int            run_n, hold, t_acc;
  job_t          cur;
  job_t          jq[$];
  int            opq[$];
  int            res_log[$], err_log[$], run_log[$], lat_log[$], hold_log[$];
  int            ready_mode;
  bit            force_valid, stray_en;
  logic [DW*NI-1:0] exp_md;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    res_log.delete(); err_log.delete(); run_log.delete(); lat_log.delete(); hold_log.delete();
  endtask

  task automatic model_reset();
    ph = P_COL; idx = 0; m_rdy = 0; m_res = '0; m_err = 0; run_n = 0; hold = 0;
    for (int i = 0; i < NI; i++) ops[i] = '0;
    opq.delete(); jq.delete();
  endtask

  task automatic model_step();
    int prod;
    cyc++;
    if (!rst) begin
      model_reset();
      return;
    end
    case (ph)
      P_COL: if (op_valid && m_rdy) begin
        ops[idx] = op_data;
        if (opq.size() > 0) void'(opq.pop_front());
        if (idx == NI - 1) begin idx = 0; ph = P_LAU; t_acc = cyc; end
        else idx++;
      end
      P_LAU: begin
        run_n = 0; ph = P_RUN;
        cur = (jq.size() > 0) ? jq.pop_front() : '{$urandom_range(1, 20), -1};
        prod = 1;
        for (int i = 0; i < NI; i++) prod = prod * int'(ops[i]);
        if (cur.res < 0) cur.res = prod;
      end
      P_RUN: begin
        run_n++;
        if (mul_done) begin m_res = mul_result; m_err = 0; ph = P_RES; end
        else if (run_n == TO) begin m_res = '0; m_err = 1; ph = P_RES; end
        if (ph == P_RES) begin
          hold = 0;
          run_log.push_back(run_n);
          lat_log.push_back(cyc - t_acc + 1);
        end
      end
      default: begin
        hold++;
        if (res_ready) begin
          ph = P_COL;
          res_log.push_back(int'(m_res)); err_log.push_back(int'(m_err)); hold_log.push_back(hold);
        end
      end
    endcase
    m_rdy = (ph == P_COL);
  endtask

  task automatic drive_inputs();
    op_valid = (opq.size() > 0) && (force_valid || $urandom_range(0, 2) != 0);
    op_data  = op_valid ? DW'(opq[0]) : DW'($urandom);
    case (ready_mode)
      0: res_ready = 1'b0;
      1: res_ready = 1'b1;
      default: res_ready = ($urandom_range(0, 2) == 0);
    endcase
    if (ph == P_RUN && cur.lat != 0 && run_n + 1 == cur.lat) begin
      mul_done = 1'b1; mul_result = RW'(cur.res);
    end else begin
      mul_done = (ph != P_RUN && stray_en) ? ($urandom_range(0, 5) == 0) : 1'b0;
      mul_result = RW'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    drive_inputs();
  endtask

  task automatic wait_res(input int n, input int budget, input string name);
    while (res_log.size() < n && budget > 0) begin tick(); budget--; end
    chk({name, " result count"}, res_log.size(), n);
  endtask

  task automatic wait_ph(input int p, input int budget, input string name);
    while (ph != p && budget > 0) begin tick(); budget--; end
    chk({name, " phase reached"}, ph, p);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) exp_md[i*DW +: DW] = ops[i];
    chk("op_ready", op_ready, m_rdy);
    chk("busy", busy, ph != P_COL);
    chk("mul_clr", mul_clr, ph == P_LAU);
    chk("mul_en", mul_en, ph == P_RUN);
    chk("res_valid", res_valid, ph == P_RES);
    chk("mul_data", mul_data, exp_md);
    if (ph == P_RES || !rst) begin
      chk("res_data", res_data, m_res);
      chk("res_err", res_err, m_err);
    end
  end

  initial begin
    model_reset();
    op_valid = 0; op_data = '0; res_ready = 0; mul_done = 0; mul_result = '0;
    stray_en = 1; ready_mode = 1; force_valid = 0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("T1 op_ready after release", op_ready, 1'b1);

    // T2 basic job
    clear_logs();
    jq.push_back('{40, -1}); opq.push_back(20); opq.push_back(12);
    wait_res(1, 200, "T2");
    if (res_log.size() == 1) begin
      chk("T2 res_data", res_log[0], 240);
      chk("T2 res_err", err_log[0], 0);
      chk("T2 accept to res_valid", lat_log[0], 42);
      chk("T2 run cycles", run_log[0], 40);
    end
    chk("T2 dut mul_data", mul_data, {5'd12, 5'd20});

    // T3 result backpressure
    clear_logs();
    ready_mode = 0;
    jq.push_back('{5, -1}); opq.push_back(20); opq.push_back(12);
    wait_ph(P_RES, 100, "T3");
    repeat (10) tick();
    ready_mode = 1; res_ready = 1'b1;
    wait_res(1, 20, "T3");
    if (res_log.size() == 1) begin
      chk("T3 res_data", res_log[0], 240);
      chk("T3 valid hold cycles", hold_log[0], 11);
    end

    // T4 timeout
    clear_logs();
    ready_mode = 2;
    jq.push_back('{0, -1}); opq.push_back(3); opq.push_back(7);
    wait_res(1, 300, "T4");
    if (res_log.size() == 1) begin
      chk("T4 res_data", res_log[0], 0);
      chk("T4 res_err", err_log[0], 1);
      chk("T4 run cycles", run_log[0], TO);
    end

    // T5 done on the timeout cycle
    clear_logs();
    jq.push_back('{TO, 99}); opq.push_back(9); opq.push_back(9);
    wait_res(1, 300, "T5");
    if (res_log.size() == 1) begin
      chk("T5 res_data", res_log[0], 99);
      chk("T5 res_err", err_log[0], 0);
      chk("T5 run cycles", run_log[0], TO);
    end

    // T1 reset mid-RUN, then reset with a partial operand set
    clear_logs();
    jq.push_back('{0, -1}); opq.push_back(5); opq.push_back(6);
    wait_ph(P_RUN, 100, "T1");
    repeat (5) tick();
    rst = 1'b0;
    model_reset();
    #1;
    chk("T1 busy in reset", busy, 1'b0);
    chk("T1 mul_en in reset", mul_en, 1'b0);
    chk("T1 res_valid in reset", res_valid, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("T1 op_ready after mid-job reset", op_ready, 1'b1);
    opq.push_back(7);
    for (int b = 0; b < 50 && idx != 1; b++) tick();
    chk("T1 partial word taken", idx, 1);
    rst = 1'b0;
    model_reset();
    repeat (2) tick();
    rst = 1'b1;
    jq.push_back('{2, -1}); opq.push_back(4); opq.push_back(5);
    wait_res(1, 200, "T1 fresh");
    if (res_log.size() == 1) chk("T1 fresh res_data", res_log[0], 20);

    // T6 back-to-back jobs with stray done pulses
    clear_logs();
    force_valid = 1; ready_mode = 1;
    foreach (opq[i]) ;
    opq.push_back(31); opq.push_back(31); opq.push_back(0);
    opq.push_back(17); opq.push_back(1); opq.push_back(1);
    for (int j = 0; j < 3; j++) jq.push_back('{$urandom_range(1, 10), -1});
    wait_res(3, 300, "T6");
    if (res_log.size() == 3) begin
      chk("T6 job0", res_log[0], 961);
      chk("T6 job1", res_log[1], 0);
      chk("T6 job2", res_log[2], 1);
      chk("T6 errs", err_log[0] + err_log[1] + err_log[2], 0);
    end

    // Randomized jobs: mixed latencies, timeouts, overrides, gaps and backpressure
    clear_logs();
    force_valid = 0; ready_mode = 2;
    for (int j = 0; j < 40; j++) begin
      for (int k = 0; k < NI; k++) opq.push_back($urandom_range(0, 31));
      jq.push_back('{($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : -1});
    end
    wait_res(40, 8000, "random");

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
